// File: rtl/fast_pkg.sv
// Shared types and width helpers for the FAST contiguity stage.
package fast_pkg;

    localparam int N_PIX_DEF = 16;

    // Result fields are sized for circles of up to 255 points; lanes use the low bits.
    localparam int RES_RUN_W = 8;
    localparam int RES_IDX_W = 8;

    function automatic int run_w(input int n_pix);
        return $clog2(n_pix + 1);
    endfunction

    function automatic int idx_w(input int n_pix);
        return $clog2(n_pix);
    endfunction

    typedef struct packed {
        logic                 contig;
        logic                 is_dark;
        logic                 is_bright;
        logic [RES_RUN_W-1:0] max_run;
        logic [RES_IDX_W-1:0] arc_start;
    } lane_res_t;

endpackage

// File: rtl/fast_contig_detector_if.sv
// Beat-level bus between the circle-compare stage and the score/NMS stage.
interface fast_contig_detector_if #(
    parameter int N_PIX = fast_pkg::N_PIX_DEF,
    parameter int LANES = 1,
    parameter int RUN_W = fast_pkg::run_w(N_PIX),
    parameter int IDX_W = fast_pkg::idx_w(N_PIX)
);
    logic                   in_valid;
    logic [LANES*N_PIX-1:0] input_d;
    logic [LANES*N_PIX-1:0] input_b;
    logic [RUN_W-1:0]       arc_thresh;

    logic                   out_valid;
    logic [LANES-1:0]       contig;
    logic [LANES-1:0]       is_dark;
    logic [LANES-1:0]       is_bright;
    logic [LANES*RUN_W-1:0] max_run;
    logic [LANES*IDX_W-1:0] arc_start;

    modport master (
        output in_valid, input_d, input_b, arc_thresh,
        input  out_valid, contig, is_dark, is_bright, max_run, arc_start
    );

    modport slave (
        input  in_valid, input_d, input_b, arc_thresh,
        output out_valid, contig, is_dark, is_bright, max_run, arc_start
    );
endinterface

// File: rtl/fast_contig_detector_run_len.sv
// Longest circular run of ones in one circle mask; ties resolve to the smallest start.
module contig_run_len #(
    parameter int N_PIX = 16,
    parameter int RUN_W = $clog2(N_PIX + 1),
    parameter int IDX_W = $clog2(N_PIX)
) (
    input  logic [N_PIX-1:0] mask,
    output logic [RUN_W-1:0] run_len,
    output logic [IDX_W-1:0] run_start
);
    logic [2*N_PIX-1:0] wrapped;

    assign wrapped = {mask, mask};

    // NOTE: search state uses blocking assignments so each start sees the previous result.
    always_comb begin
        int   best_len;
        int   best_start;
        int   len;
        logic open;
        best_len   = 0;
        best_start = 0;
        len        = 0;
        open       = 1'b0;
        for (int s = 0; s < N_PIX; s++) begin
            len  = 0;
            open = 1'b1;
            for (int k = 0; k < N_PIX; k++) begin
                if (open && wrapped[s + k]) len = len + 1;
                else open = 1'b0;
            end
            if (len > best_len) begin
                best_len   = len;
                best_start = s;
            end
        end
        run_len   = RUN_W'(best_len);
        run_start = IDX_W'(best_start);
    end

endmodule

// File: rtl/fast_contig_detector.sv
// Multi-lane FAST contiguity stage: run search, threshold compare, alignment delay.
module fast_contig_detector
    import fast_pkg::*;
#(
    parameter int N_PIX = N_PIX_DEF,
    parameter int LANES = 1,
    parameter int DELAY = 2,
    parameter int RUN_W = run_w(N_PIX),
    parameter int IDX_W = idx_w(N_PIX)
) (
    input logic                   clk,
    input logic                   rst,
    input logic                   ce,
    fast_contig_detector_if.slave bus
);
    logic [RUN_W-1:0] run_d_c [LANES];
    logic [RUN_W-1:0] run_b_c [LANES];
    logic [IDX_W-1:0] st_d_c  [LANES];
    logic [IDX_W-1:0] st_b_c  [LANES];

    logic             s1_valid;
    logic [RUN_W-1:0] s1_thresh;
    logic [RUN_W-1:0] s1_run_d [LANES];
    logic [RUN_W-1:0] s1_run_b [LANES];
    logic [IDX_W-1:0] s1_st_d  [LANES];
    logic [IDX_W-1:0] s1_st_b  [LANES];

    lane_res_t [LANES-1:0] s2_next;

    // Index 0 is the stage-2 register; DELAY further stages follow.
    logic                  pipe_valid [DELAY+1];
    lane_res_t [LANES-1:0] pipe_res   [DELAY+1];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        contig_run_len #(.N_PIX(N_PIX), .RUN_W(RUN_W), .IDX_W(IDX_W)) u_run_d (
            .mask      (bus.input_d[k*N_PIX +: N_PIX]),
            .run_len   (run_d_c[k]),
            .run_start (st_d_c[k])
        );
        contig_run_len #(.N_PIX(N_PIX), .RUN_W(RUN_W), .IDX_W(IDX_W)) u_run_b (
            .mask      (bus.input_b[k*N_PIX +: N_PIX]),
            .run_len   (run_b_c[k]),
            .run_start (st_b_c[k])
        );
    end

    always_comb begin
        s2_next = '0;
        for (int k = 0; k < LANES; k++) begin
            s2_next[k].is_dark   = (s1_run_d[k] >= s1_thresh);
            s2_next[k].is_bright = (s1_run_b[k] >= s1_thresh);
            s2_next[k].contig    = s2_next[k].is_dark | s2_next[k].is_bright;
            // Equal runs report the darker mask.
            if (s1_run_b[k] > s1_run_d[k]) begin
                s2_next[k].max_run   = RES_RUN_W'(s1_run_b[k]);
                s2_next[k].arc_start = RES_IDX_W'(s1_st_b[k]);
            end else begin
                s2_next[k].max_run   = RES_RUN_W'(s1_run_d[k]);
                s2_next[k].arc_start = RES_IDX_W'(s1_st_d[k]);
            end
        end
    end

    // NOTE: data registers are reset too, because every output must read 0 while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_thresh     <= '0;
            for (int k = 0; k < LANES; k++) begin
                s1_run_d[k] <= '0;
                s1_run_b[k] <= '0;
                s1_st_d[k]  <= '0;
                s1_st_b[k]  <= '0;
            end
            pipe_valid[0] <= 1'b0;
            pipe_res[0]   <= '0;
        end else if (ce) begin
            s1_valid      <= bus.in_valid;
            s1_thresh     <= bus.arc_thresh;
            for (int k = 0; k < LANES; k++) begin
                s1_run_d[k] <= run_d_c[k];
                s1_run_b[k] <= run_b_c[k];
                s1_st_d[k]  <= st_d_c[k];
                s1_st_b[k]  <= st_b_c[k];
            end
            pipe_valid[0] <= s1_valid;
            pipe_res[0]   <= s2_next;
        end
    end

    for (genvar g = 1; g <= DELAY; g++) begin : g_delay
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_valid[g] <= 1'b0;
                pipe_res[g]   <= '0;
            end else if (ce) begin
                pipe_valid[g] <= pipe_valid[g-1];
                pipe_res[g]   <= pipe_res[g-1];
            end
        end
    end

    // High bits of the shared result fields are padding for small circles.
    logic unused_res_pad;
    assign unused_res_pad = ^pipe_res[DELAY];

    always_comb begin
        bus.out_valid = pipe_valid[DELAY];
        bus.contig    = '0;
        bus.is_dark   = '0;
        bus.is_bright = '0;
        bus.max_run   = '0;
        bus.arc_start = '0;
        for (int k = 0; k < LANES; k++) begin
            bus.contig[k]                   = pipe_res[DELAY][k].contig;
            bus.is_dark[k]                  = pipe_res[DELAY][k].is_dark;
            bus.is_bright[k]                = pipe_res[DELAY][k].is_bright;
            bus.max_run[k*RUN_W +: RUN_W]   = pipe_res[DELAY][k].max_run[RUN_W-1:0];
            bus.arc_start[k*IDX_W +: IDX_W] = pipe_res[DELAY][k].arc_start[IDX_W-1:0];
        end
    end

endmodule

// File: tb/tb_fast_contig_detector.sv
// Bench: two-lane DELAY=2 instance and one-lane DELAY=0 instance against a run-scanning reference model.
module tb_fast_contig_detector;
    import fast_pkg::*;

    localparam int NP    = 16;
    localparam int LA    = 2;
    localparam int LB    = 1;
    localparam int LAT_A = 4;
    localparam int LAT_B = 2;

    typedef struct packed {
        logic            valid;
        logic [1:0]      contig;
        logic [1:0]      dark;
        logic [1:0]      bright;
        logic [1:0][4:0] run;
        logic [1:0][3:0] start;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    int checks = 0;
    int errors = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t cur_a;
    exp_t cur_b;

    fast_contig_detector_if #(.N_PIX(NP), .LANES(LA)) bus_a ();
    fast_contig_detector_if #(.N_PIX(NP), .LANES(LB)) bus_b ();

    fast_contig_detector #(.N_PIX(NP), .LANES(LA), .DELAY(2)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (bus_a)
    );

    fast_contig_detector #(.N_PIX(NP), .LANES(LB), .DELAY(0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    // Scan the mask written out twice and keep the longest maximal run seen.
    function automatic void ref_run(input logic [15:0] m, output int len, output int st);
        int cur;
        int cs;
        len = 0;
        st  = 0;
        cur = 0;
        cs  = 0;
        if (m == 16'hFFFF) begin
            len = 16;
            return;
        end
        for (int i = 0; i < 32; i++) begin
            if (m[i % 16]) begin
                if (cur == 0) cs = i % 16;
                cur = cur + 1;
                if (cur > len || (cur == len && cs < st)) begin
                    len = cur;
                    st  = cs;
                end
            end else begin
                cur = 0;
            end
        end
    endfunction

    function automatic exp_t model(input logic v, input logic [31:0] d, input logic [31:0] b,
                                   input logic [4:0] th, input int lanes);
        exp_t e;
        int   rd, sd, rb, sb;
        e       = '0;
        e.valid = v;
        for (int k = 0; k < lanes; k++) begin
            ref_run(d[k*16 +: 16], rd, sd);
            ref_run(b[k*16 +: 16], rb, sb);
            e.dark[k]   = (rd >= int'(th));
            e.bright[k] = (rb >= int'(th));
            e.contig[k] = e.dark[k] | e.bright[k];
            e.run[k]    = (rb > rd) ? 5'(rb) : 5'(rd);
            e.start[k]  = (rb > rd) ? 4'(sb) : 4'(sd);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("a.out_valid", 32'(bus_a.out_valid), 32'(cur_a.valid));
        if (cur_a.valid) begin
            for (int k = 0; k < LA; k++) begin
                check($sformatf("a.contig[%0d]", k), 32'(bus_a.contig[k]), 32'(cur_a.contig[k]));
                check($sformatf("a.is_dark[%0d]", k), 32'(bus_a.is_dark[k]), 32'(cur_a.dark[k]));
                check($sformatf("a.is_bright[%0d]", k), 32'(bus_a.is_bright[k]), 32'(cur_a.bright[k]));
                check($sformatf("a.max_run[%0d]", k), 32'(bus_a.max_run[k*5 +: 5]), 32'(cur_a.run[k]));
                check($sformatf("a.arc_start[%0d]", k), 32'(bus_a.arc_start[k*4 +: 4]), 32'(cur_a.start[k]));
            end
        end
        check("b.out_valid", 32'(bus_b.out_valid), 32'(cur_b.valid));
        if (cur_b.valid) begin
            check("b.contig", 32'(bus_b.contig), 32'(cur_b.contig[0]));
            check("b.is_dark", 32'(bus_b.is_dark), 32'(cur_b.dark[0]));
            check("b.is_bright", 32'(bus_b.is_bright), 32'(cur_b.bright[0]));
            check("b.max_run", 32'(bus_b.max_run), 32'(cur_b.run[0]));
            check("b.arc_start", 32'(bus_b.arc_start), 32'(cur_b.start[0]));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " a.out_valid"}, 32'(bus_a.out_valid), 32'd0);
        check({tag, " a.flags"}, {26'd0, bus_a.contig, bus_a.is_dark, bus_a.is_bright}, 32'd0);
        check({tag, " a.max_run"}, 32'(bus_a.max_run), 32'd0);
        check({tag, " a.arc_start"}, 32'(bus_a.arc_start), 32'd0);
        check({tag, " b.out_valid"}, 32'(bus_b.out_valid), 32'd0);
        check({tag, " b.flags"}, {29'd0, bus_b.contig, bus_b.is_dark, bus_b.is_bright}, 32'd0);
        check({tag, " b.max_run"}, 32'(bus_b.max_run), 32'd0);
        check({tag, " b.arc_start"}, 32'(bus_b.arc_start), 32'd0);
    endtask

    task automatic model_clear();
        qa.delete();
        qb.delete();
        for (int i = 0; i < LAT_A - 1; i++) qa.push_back('0);
        for (int i = 0; i < LAT_B - 1; i++) qb.push_back('0);
        cur_a = '0;
        cur_b = '0;
    endtask

    task automatic step(input logic c, input logic v, input logic [31:0] d, input logic [31:0] b,
                        input logic [4:0] th);
        @(negedge clk);
        ce               = c;
        bus_a.in_valid   = v;
        bus_a.input_d    = d;
        bus_a.input_b    = b;
        bus_a.arc_thresh = th;
        bus_b.in_valid   = v;
        bus_b.input_d    = d[15:0];
        bus_b.input_b    = b[15:0];
        bus_b.arc_thresh = th;
        @(posedge clk);
        if (c) begin
            qa.push_back(model(v, d, b, th, LA));
            cur_a = qa.pop_front();
            qb.push_back(model(v, d, b, th, LB));
            cur_b = qb.pop_front();
        end
        #1 compare_all();
    endtask

    function automatic logic [15:0] rnd_mask();
        logic [31:0] arc;
        int          len;
        int          rot;
        case ($urandom_range(0, 4))
            0: return 16'hFFFF;
            1: return 16'h0000;
            2: return 16'($urandom);
            default: begin
                len = $urandom_range(1, 15);
                rot = $urandom_range(0, 15);
                arc = (32'd1 << len) - 32'd1;
                arc = arc << rot;
                return arc[15:0] | arc[31:16];
            end
        endcase
    endfunction

    // Drive one beat, then idle; the DELAY=0 copy shows it after 2 edges, the other after 4.
    task automatic directed(input string tag, input logic [15:0] d, input logic [15:0] b,
                            input logic [4:0] th, input logic ec, input logic ed, input logic eb,
                            input int er, input int es);
        step(1'b1, 1'b1, {16'($urandom), d}, {16'($urandom), b}, th);
        step(1'b1, 1'b0, 32'd0, 32'd0, 5'd0);
        check({tag, " b.valid"}, 32'(bus_b.out_valid), 32'd1);
        check({tag, " b.flags"}, {29'd0, bus_b.contig, bus_b.is_dark, bus_b.is_bright}, {29'd0, ec, ed, eb});
        check({tag, " b.max_run"}, 32'(bus_b.max_run), 32'(er));
        check({tag, " b.arc_start"}, 32'(bus_b.arc_start), 32'(es));
        step(1'b1, 1'b0, 32'd0, 32'd0, 5'd0);
        step(1'b1, 1'b0, 32'd0, 32'd0, 5'd0);
        check({tag, " a.valid"}, 32'(bus_a.out_valid), 32'd1);
        check({tag, " a.flags"}, {29'd0, bus_a.contig[0], bus_a.is_dark[0], bus_a.is_bright[0]}, {29'd0, ec, ed, eb});
        check({tag, " a.max_run"}, 32'(bus_a.max_run[4:0]), 32'(er));
        check({tag, " a.arc_start"}, 32'(bus_a.arc_start[3:0]), 32'(es));
    endtask

    initial begin
        logic [3:0] ce_pat;
        int         beats;
        rst              = 1'b1;
        ce               = 1'b0;
        bus_a.in_valid   = 1'b0;
        bus_a.input_d    = '0;
        bus_a.input_b    = '0;
        bus_a.arc_thresh = '0;
        bus_b.in_valid   = 1'b0;
        bus_b.input_d    = '0;
        bus_b.input_b    = '0;
        bus_b.arc_thresh = '0;
        model_clear();
        @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        directed("dark_arc",   16'hFF80, 16'h0000, 5'd9,  1'b1, 1'b1, 1'b0, 9,  7);
        directed("wrap_arc",   16'h0000, 16'h80FF, 5'd9,  1'b1, 1'b0, 1'b1, 9,  15);
        directed("wrap_th10",  16'h0000, 16'h80FF, 5'd10, 1'b0, 1'b0, 1'b0, 9,  15);
        directed("ones_th16",  16'hFFFF, 16'hFFFF, 5'd16, 1'b1, 1'b1, 1'b1, 16, 0);
        directed("ones_th17",  16'hFFFF, 16'hFFFF, 5'd17, 1'b0, 1'b0, 1'b0, 16, 0);
        directed("tie_dark",   16'h00F0, 16'h0F00, 5'd4,  1'b1, 1'b1, 1'b1, 4,  4);
        directed("tie_lowidx", 16'h0F0F, 16'h0F00, 5'd4,  1'b1, 1'b1, 1'b1, 4,  0);
        directed("zero_th0",   16'h0000, 16'h0000, 5'd0,  1'b1, 1'b1, 1'b1, 0,  0);

        // Eight back-to-back beats under a 1,0,0,1 clock-enable pattern, then drain.
        ce_pat = 4'b1001;
        beats  = 0;
        for (int i = 0; i < 40; i++) begin
            if (ce_pat[i % 4] && beats < 8) begin
                step(1'b1, 1'b1, {rnd_mask(), rnd_mask()}, {rnd_mask(), rnd_mask()}, 5'($urandom_range(0, 17)));
                beats++;
            end else begin
                step(ce_pat[i % 4], 1'b0, 32'($urandom), 32'($urandom), 5'($urandom_range(0, 17)));
            end
        end

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), {rnd_mask(), rnd_mask()},
                 {rnd_mask(), rnd_mask()}, 5'($urandom_range(0, 17)));
        end

        // Mid-stream reset with three beats inside the DELAY=2 pipeline.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, {rnd_mask(), rnd_mask()}, {rnd_mask(), rnd_mask()}, 5'd0);
        end
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        model_clear();
        @(posedge clk);
        #1 check_zero("rst_held");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 32'($urandom), 32'($urandom), 5'd0);
        end

        for (int i = 0; i < 100; i++) begin
            step(1'($urandom_range(0, 2) != 0), 1'($urandom), {rnd_mask(), rnd_mask()},
                 {rnd_mask(), rnd_mask()}, 5'($urandom_range(0, 17)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fast_contig_detector.md
# fast_contig_detector

Parametrised, multi-lane contiguity stage of the FAST corner pipeline. For each lane it takes the darker and brighter comparison masks of an N_PIX-point Bresenham circle and finds the longest circular run of set bits in each mask. It reports whether that run meets a per-pixel arc threshold, plus the run length, start index and polarity. The block sits between the circle-compare stage and the score/NMS stage. A configurable alignment delay keeps it in step with the parallel score path.

## Interface
- N_PIX, 16: circle points per pixel (≥ 4).
- LANES, 1: pixels processed per clock.
- DELAY, 2: extra alignment register stages after the compare stage (≥ 0).
- RUN_W, $clog2(N_PIX+1): run-length/threshold width (derived; do not override).
- IDX_W, $clog2(N_PIX): start-index width (derived).
- clk  in  1  clock, the only clock domain.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; every register in the block advances only when high.
- in_valid  in  1  input beat is valid.
- input_d  in  LANES*N_PIX  darker masks; lane k occupies bits [k*N_PIX +: N_PIX]; bit i is circle point i.
- input_b  in  LANES*N_PIX  brighter masks, same packing.
- arc_thresh  in  RUN_W  minimum arc length, sampled with the beat and shared by all lanes.
- out_valid  out  1  output beat is valid.
- contig  out  LANES  lane meets the threshold.
- is_dark / is_bright  out  LANES each  the darker / brighter mask alone meets the threshold.
- max_run  out  LANES*RUN_W  longest circular run over both masks.
- arc_start  out  LANES*IDX_W  start index of the run reported in max_run.

## Operation
- Circular run: bits N_PIX-1 and 0 are adjacent. A run has a start index s and length L, covering bits s, s+1, … mod N_PIX.
- All-ones mask: L = N_PIX, s = 0. All-zeros mask: L = 0, s = 0.
- Per mask, choose the longest run. On a tie, choose the smallest s.
- max_run is the larger of the darker and brighter runs; arc_start belongs to that run. If both are equal, the darker mask wins.
- is_dark = (run_d ≥ arc_thresh); is_bright = (run_b ≥ arc_thresh); contig = is_dark | is_bright.
- arc_thresh = 0 makes contig = 1 for every valid beat. arc_thresh > N_PIX makes contig = 0 always.
- Both is_dark and is_bright may be 1 at once; report both, do not arbitrate.
- Outputs are qualified by out_valid. Data fields on invalid beats still propagate and have no required value.

## Timing
- Stage 1 (ce): register run_d, run_b and both start indices per lane, together with arc_thresh and in_valid.
- Stage 2 (ce): compare against the threshold, select max/start, and register the flags.
- DELAY further ce-gated stages then carry all outputs and valid.
- Latency is 2 + DELAY ce-high cycles from input beat to output. The default is 4.
- Full throughput: one beat per ce-high cycle, with no back-pressure.
- ce low: every stage holds, including out_valid. No beat is lost or duplicated.
- rst asserted, at any time including mid-stream: all registers clear asynchronously.
  - out_valid, contig, is_dark, is_bright = 0; max_run = 0; arc_start = 0.
  - In-flight beats are discarded.
- First valid output appears 2 + DELAY ce-cycles after the first in_valid following rst release.

## Structure
- Shared package fast_pkg holds:
  - the default N_PIX constant;
  - the RUN_W/IDX_W helper functions;
  - a per-lane result struct (contig, is_dark, is_bright, max_run, arc_start).
- Sub-module contig_run_len: purely combinational. It takes a mask of N_PIX bits and returns the longest circular run length and its start index. It is instantiated 2×LANES times, and its output feeds stage 1.
- The delay line is a generate loop over DELAY; DELAY = 0 connects stage 2 directly to the outputs.

## Test plan
- N_PIX=16, thresh=9, input_d=16'hFF80, input_b=0 → after 4 cycles: contig=1, is_dark=1, max_run=9, arc_start=7.
- Wrap case: input_b=16'h80FF, thresh=9 → is_bright=1, max_run=9, arc_start=15. With thresh=10 on the same input → contig=0, max_run=9.
- Masks all ones in both, thresh=16 → is_dark=is_bright=contig=1, max_run=16, arc_start=0. With thresh=17 → contig=0.
- Tie rule: input_d=16'h00F0 and input_b=16'h0F00, thresh=4 → both flags set, max_run=4, arc_start=4 (darker wins). Also input_d=16'h0F0F → arc_start=0.
- LANES=2 with a back-to-back stream of 8 beats, and ce toggled 1,0,0,1… → outputs in order, each held while ce=0, latency counted in ce-high cycles only.
- Assert rst for 1 cycle with 3 beats in flight → all outputs 0 immediately with no clock edge, and none of the 3 beats ever appears. DELAY=0 build → latency 2.
